morse_encoder: RTL

MORSE_ENCODER -- requirements
Module: morse_encoder

---
 rtl/morse_pkg.sv | 37 +++
 rtl/morse_rom.sv | 74 +++++++
 rtl/morse_encoder.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/morse_pkg.sv
// Shared definitions for the Morse encoder: FSM states, pattern/length
// widths, element and gap durations in Morse units, and the space code.
package morse_pkg;

  // Pattern storage is six elements wide so punctuation fits when enabled.
  localparam int PAT_W = 6;
  localparam int LEN_W = 3;

  // Durations in Morse time units.
  localparam logic [LEN_W-1:0] DIT_UNITS        = 3'd1;
  localparam logic [LEN_W-1:0] DAH_UNITS        = 3'd3;
  localparam logic [LEN_W-1:0] ELEM_GAP_UNITS   = 3'd1;
  localparam logic [LEN_W-1:0] LETTER_GAP_UNITS = 3'd3;
  localparam logic [LEN_W-1:0] WORD_GAP_UNITS   = 3'd4;

  localparam logic [7:0] SPACE_CODE = 8'h20;

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    ELEM_GAP,
    LETTER_GAP,
    WORD_GAP
  } state_e;

  // Left-align a pattern so the first element to send sits in the MSB.
  function automatic logic [PAT_W-1:0] align_pattern(input logic [PAT_W-1:0] pat,
                                                      input logic [LEN_W-1:0] len);
    return pat << (LEN_W'(PAT_W) - len);
  endfunction

  // Units-remaining preload for a mark: the counter holds (units - 1).
  function automatic logic [LEN_W-1:0] mark_preload(input logic is_dah);
    return is_dah ? (DAH_UNITS - 3'd1) : (DIT_UNITS - 3'd1);
  endfunction

endpackage

// File: rtl/morse_rom.sv
// Combinational character-to-Morse lookup. Patterns are right-aligned,
// 1 = dah, the most significant used bit is sent first. Lowercase letters
// fold onto uppercase. Build option: MORSE_PUNCT_EN adds '.', ',' and '?'.
module morse_rom
  import morse_pkg::*;
(
  input  logic [7:0]       letter,
  output logic [PAT_W-1:0] pattern,
  output logic [LEN_W-1:0] len,
  output logic             supported
);

  logic [7:0] folded;

  // Case-fold, then decode the ITU pattern and its element count.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    folded    = letter;
    pattern   = '0;
    len       = '0;
    supported = 1'b1;
    if (letter >= 8'h61 && letter <= 8'h7a) begin
      folded = letter - 8'h20;
    end
    case (folded)
      "A": begin pattern = 6'b000001; len = 3'd2; end
      "B": begin pattern = 6'b001000; len = 3'd4; end
      "C": begin pattern = 6'b001010; len = 3'd4; end
      "D": begin pattern = 6'b000100; len = 3'd3; end
      "E": begin pattern = 6'b000000; len = 3'd1; end
      "F": begin pattern = 6'b000010; len = 3'd4; end
      "G": begin pattern = 6'b000110; len = 3'd3; end
      "H": begin pattern = 6'b000000; len = 3'd4; end
      "I": begin pattern = 6'b000000; len = 3'd2; end
      "J": begin pattern = 6'b000111; len = 3'd4; end
      "K": begin pattern = 6'b000101; len = 3'd3; end
      "L": begin pattern = 6'b000100; len = 3'd4; end
      "M": begin pattern = 6'b000011; len = 3'd2; end
      "N": begin pattern = 6'b000010; len = 3'd2; end
      "O": begin pattern = 6'b000111; len = 3'd3; end
      "P": begin pattern = 6'b000110; len = 3'd4; end
      "Q": begin pattern = 6'b001101; len = 3'd4; end
      "R": begin pattern = 6'b000010; len = 3'd3; end
      "S": begin pattern = 6'b000000; len = 3'd3; end
      "T": begin pattern = 6'b000001; len = 3'd1; end
      "U": begin pattern = 6'b000001; len = 3'd3; end
      "V": begin pattern = 6'b000001; len = 3'd4; end
      "W": begin pattern = 6'b000011; len = 3'd3; end
      "X": begin pattern = 6'b001001; len = 3'd4; end
      "Y": begin pattern = 6'b001011; len = 3'd4; end
      "Z": begin pattern = 6'b001100; len = 3'd4; end
      "0": begin pattern = 6'b011111; len = 3'd5; end
      "1": begin pattern = 6'b001111; len = 3'd5; end
      "2": begin pattern = 6'b000111; len = 3'd5; end
      "3": begin pattern = 6'b000011; len = 3'd5; end
      "4": begin pattern = 6'b000001; len = 3'd5; end
      "5": begin pattern = 6'b000000; len = 3'd5; end
      "6": begin pattern = 6'b010000; len = 3'd5; end
      "7": begin pattern = 6'b011000; len = 3'd5; end
      "8": begin pattern = 6'b011100; len = 3'd5; end
      "9": begin pattern = 6'b011110; len = 3'd5; end
`ifdef MORSE_PUNCT_EN
      ".": begin pattern = 6'b010101; len = 3'd6; end
      ",": begin pattern = 6'b110011; len = 3'd6; end
      "?": begin pattern = 6'b001100; len = 3'd6; end
`else
      // Punctuation falls through to unsupported in the base build.
`endif
      default: supported = 1'b0;
    endcase
  end

endmodule

// File: rtl/morse_encoder.sv
// Morse keyer: accepts one ASCII character per handshake and keys it onto
// 'signal' with standard dit/dah/gap timing; space produces a word gap.
// Build option: MORSE_PUNCT_EN (passed through to morse_rom).
// The final gap of every character includes the IDLE cycle in which the
// next character is accepted, so back-to-back characters keep an exact
// (units x UNIT_CYCLES) period with no extra dead cycle.
module morse_encoder
  import morse_pkg::*;
#(
  parameter int WIDTH       = 27,
  parameter int UNIT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] letter,
  input  logic       letter_valid,
  output logic       letter_ready,
  output logic       signal,
  output logic       busy
);

  localparam logic [WIDTH-1:0] LAST_CNT   = WIDTH'(UNIT_CYCLES - 1);
  localparam logic [WIDTH-1:0] PENULT_CNT = WIDTH'((UNIT_CYCLES > 1) ? UNIT_CYCLES - 2 : 0);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   unit_cnt_q, unit_cnt_d;
  logic [LEN_W-1:0]   units_left_q, units_left_d;
  logic [PAT_W-1:0]   shift_q, shift_d;
  logic [LEN_W-1:0]   elem_left_q, elem_left_d;
  logic               signal_q, signal_d;

  logic [PAT_W-1:0]   rom_pattern;
  logic [LEN_W-1:0]   rom_len;
  logic               rom_supported;
  logic [PAT_W-1:0]   rom_aligned;

  logic               unit_end;
  logic               seg_end;
  logic               final_end;
  logic               is_space;

  morse_rom u_rom (
    .letter    (letter),
    .pattern   (rom_pattern),
    .len       (rom_len),
    .supported (rom_supported)
  );

  assign rom_aligned = align_pattern(rom_pattern, rom_len);
  assign is_space    = (letter == SPACE_CODE);

  // A unit ends on the last timer count; a segment ends on the last unit.
  // The closing gap of a character ends one cycle early so that the IDLE
  // cycle completes its final unit.
  assign unit_end  = (unit_cnt_q == LAST_CNT);
  assign seg_end   = unit_end && (units_left_q == '0);
  assign final_end = (UNIT_CYCLES == 1) ? (units_left_q == 3'd1)
                                        : ((units_left_q == '0) && (unit_cnt_q == PENULT_CNT));

  // Next-state, counter and keying logic.
  always_comb begin
    state_d      = state_q;
    unit_cnt_d   = unit_end ? '0 : unit_cnt_q + WIDTH'(1);
    units_left_d = unit_end ? units_left_q - 3'd1 : units_left_q;
    shift_d      = shift_q;
    elem_left_d  = elem_left_q;

    case (state_q)
      IDLE: begin
        unit_cnt_d   = '0;
        units_left_d = '0;
        if (letter_valid) begin
          if (is_space) begin
            state_d      = WORD_GAP;
            units_left_d = WORD_GAP_UNITS - 3'd1;
          end else if (rom_supported) begin
            state_d      = MARK;
            shift_d      = rom_aligned;
            elem_left_d  = rom_len - 3'd1;
            units_left_d = mark_preload(rom_aligned[PAT_W-1]);
          end
        end
      end

      MARK: begin
        if (seg_end) begin
          if (elem_left_q == '0) begin
            state_d      = LETTER_GAP;
            units_left_d = LETTER_GAP_UNITS - 3'd1;
          end else begin
            state_d      = ELEM_GAP;
            units_left_d = ELEM_GAP_UNITS - 3'd1;
            shift_d      = shift_q << 1;
            elem_left_d  = elem_left_q - 3'd1;
          end
        end
      end

      ELEM_GAP: begin
        if (seg_end) begin
          state_d      = MARK;
          units_left_d = mark_preload(shift_q[PAT_W-1]);
        end
      end

      LETTER_GAP, WORD_GAP: begin
        if (final_end) begin
          state_d      = IDLE;
          unit_cnt_d   = '0;
          units_left_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase

    signal_d = (state_d == MARK);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from the
    // values present before the edge, independent of statement order.
    if (reset) begin
      state_q      <= IDLE;
      unit_cnt_q   <= '0;
      units_left_q <= '0;
      shift_q      <= '0;
      elem_left_q  <= '0;
      signal_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      unit_cnt_q   <= unit_cnt_d;
      units_left_q <= units_left_d;
      shift_q      <= shift_d;
      elem_left_q  <= elem_left_d;
      signal_q     <= signal_d;
    end
  end

  assign letter_ready = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign signal       = signal_q;

endmodule
